// File: rtl/csa_pkg.sv
// Shared types and default sizes for the carry-save stream accumulator.
package csa_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int ACC_W_DEF = 8;

    typedef enum logic [1:0] {
        ACCUM,
        RESOLVE,
        DONE
    } state_t;

endpackage

// File: rtl/csa_row.sv
// 3:2 compressor row: per-bit full adders producing the sum vector and the
// unshifted majority vector; weighting of the majority is left to the caller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic maj
);
    assign sum = a ^ b ^ cin;
    assign maj = (a & b) | (a & cin) | (b & cin);
endmodule

module csa_row
    import csa_pkg::*;
#(
    parameter int W = ACC_W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] maj
);
    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .sum (sum[i]),
            .maj (maj[i])
        );
    end
endmodule

// File: rtl/csa_stream_accumulator.sv
// Streaming accumulator: operands fold into a redundant S/C pair, then an
// iterative XOR/AND loop resolves the pair into a binary total with overflow.
module csa_stream_accumulator
    import csa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    state_t           state;
    logic [ACC_W-1:0] s;
    logic [ACC_W-1:0] c;
    logic             ovf;

    logic [ACC_W-1:0] x;
    logic [ACC_W-1:0] row_sum;
    logic [ACC_W-1:0] row_maj;
    logic [ACC_W-1:0] res_and;

    assign x        = ACC_W'(in_data);
    assign res_and  = s & c;
    assign in_ready = (state == ACCUM);

    csa_row #(.W(ACC_W)) u_row (
        .a   (s),
        .b   (c),
        .c   (x),
        .sum (row_sum),
        .maj (row_maj)
    );

    // Any carry shifted out of the top bit is real weight 2^ACC_W, since all
    // terms are non-negative, so the sticky flag is exact.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACCUM;
            s         <= '0;
            c         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        s <= row_sum;
                        c <= row_maj << 1;
                        if (row_maj[ACC_W-1]) ovf <= 1'b1;
                        if (in_last) state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    if (c == '0) begin
                        state <= DONE;
                    end else begin
                        s <= s ^ c;
                        c <= res_and << 1;
                        if (res_and[ACC_W-1]) ovf <= 1'b1;
                    end
                end
                DONE: begin
                    // First DONE cycle loads the output registers; the
                    // result then holds until the downstream takes it.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_sum   <= s;
                        out_ovf   <= ovf;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        s         <= '0;
                        c         <= '0;
                        ovf       <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Scoreboard bench: totals are plain integer sums pushed on last-accept and
// popped by a monitor at every output handshake.
module tb_csa_stream_accumulator;

    localparam int WIDTH = 4;
    localparam int ACC_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    csa_stream_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic             ovf;
    } res_t;

    res_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   rand_mode = 1'b0;
    bit   push_en = 1'b1;
    int   total = 0;
    int   t_acc = 0;

    logic             m_pv = 1'b0;
    logic             m_pr = 1'b0;
    logic [ACC_W-1:0] m_ps = '0;
    logic             m_po = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "aborting after timeout");
    endtask

    // Present one operand and wait for it to be taken; model updates on accept.
    task automatic send(input logic [WIDTH-1:0] d, input bit last);
        bit acc = 1'b0;
        int guard = 0;
        if (rand_mode) begin
            while ($urandom_range(0, 3) == 0) begin
                in_valid  = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (rand_mode) out_ready = 1'($urandom_range(0, 1));
            guard++;
            if (guard > 300) timeout("send_accept");
        end
        t_acc = cyc;
        total += int'(d);
        if (last) begin
            if (push_en) exp_q.push_back(res_t'{sum: total[ACC_W-1:0], ovf: (total >= 256)});
            total = 0;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(output int rise);
        int i;
        for (i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        if (!out_valid) timeout("wait_out_valid");
        rise = cyc;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) timeout("drain");
    endtask

    // Monitor: checks every accepted result and that a stalled result holds.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_pv = 1'b0;
            end else begin
                if (m_pv && !m_pr) begin
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_sum", int'(out_sum), int'(m_ps));
                    chk("hold_ovf", int'(out_ovf), int'(m_po));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_result: got sum %0d, expected no result", out_sum);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result_sum", int'(out_sum), int'(e.sum));
                        chk("result_ovf", int'(out_ovf), int'(e.ovf));
                    end
                end
                m_pv = out_valid;
                m_pr = out_ready;
                m_ps = out_sum;
                m_po = out_ovf;
            end
        end
    end

    initial begin
        #1_000_000;
        timeout("global_watchdog");
    end

    initial begin
        int t;
        int r;
        int t_first;
        int len;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_sum", int'(out_sum), 0);
        chk("reset_out_ovf", int'(out_ovf), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 3+5+7 needs one resolve step; a lone 9 needs none.
        send(4'd3, 1'b0);
        send(4'd5, 1'b0);
        send(4'd7, 1'b1);
        t = t_acc;
        wait_valid(r);
        chk("latency_3_5_7", r - t, 3);

        send(4'd9, 1'b1);
        t = t_acc;
        wait_valid(r);
        chk("latency_single", r - t, 2);

        // 16 x 15 = 240 fits; 18 x 15 = 270 wraps to 14 with overflow.
        for (int i = 0; i < 16; i++) begin
            send(4'd15, i == 15);
            if (i == 0) t_first = t_acc;
        end
        chk("throughput_16", t_acc - t_first, 15);
        for (int i = 0; i < 18; i++) begin
            send(4'd15, i == 17);
            if (i == 0) t_first = t_acc;
        end
        chk("throughput_18", t_acc - t_first, 17);
        drain();

        // Stall the result while an operand waits upstream.
        out_ready = 1'b0;
        send(4'd4, 1'b0);
        send(4'd4, 1'b1);
        wait_valid(r);
        in_valid = 1'b1;
        in_data  = 4'd6;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_out_sum", int'(out_sum), 8);
            chk("stall_out_ovf", int'(out_ovf), 0);
            chk("stall_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pending_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_q.push_back(res_t'{sum: 8'd6, ovf: 1'b0});
        @(negedge clk);
        chk("pending_taken", int'(in_ready), 0);
        drain();

        // Reset during RESOLVE discards the group entirely.
        push_en = 1'b0;
        send(4'd5, 1'b0);
        send(4'd6, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_out_sum", int'(out_sum), 0);
        chk("abort_out_ovf", int'(out_ovf), 0);
        @(posedge clk); #1;
        push_en = 1'b1;
        send(4'd1, 1'b0);
        send(4'd2, 1'b1);
        drain();

        // Random groups, gaps and backpressure; every third group biased high.
        rand_mode = 1'b1;
        for (int g = 0; g < 30; g++) begin
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                if (g % 3 == 0) send(4'($urandom_range(10, 15)), i == len - 1);
                else            send(4'($urandom_range(0, 15)), i == len - 1);
            end
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
